// File: rtl/signal_expansioner.sv
// Pulse stretcher for the data-frame generator write side.
// SIG_OUT follows SIG_IN high and then holds high for EXTEND_LEN more cycles
// after SIG_IN falls, so pre/post-acquisition samples are captured.
// Optional build macro: SIGNAL_EXPANSIONER_OUTPUT_REG_EN registers SIG_OUT
// (both edges delayed by one cycle, pulse width unchanged).
module signal_expansioner #(
    parameter int MAX_EXTEND_LEN_WIDTH = 5
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic [MAX_EXTEND_LEN_WIDTH-1:0] EXTEND_LEN,
    input  logic                            SIG_IN,
    output logic                            SIG_OUT
);

    localparam int W = MAX_EXTEND_LEN_WIDTH;

    logic [W-1:0] cnt;
    logic         stretch;

    // Down-counter: reload while SIG_IN is high, otherwise count down and stop at zero.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (SIG_IN) begin
            cnt <= EXTEND_LEN;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // Raw stretched level: the input itself or a pending extension.
    always_comb begin
        stretch = SIG_IN | (cnt != '0);
    end

`ifdef SIGNAL_EXPANSIONER_OUTPUT_REG_EN
    logic sig_q;

    // Registered output; cleared on reset so nothing leaks out after a reset edge.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= stretch;
        end
    end

    assign SIG_OUT = sig_q;
`else
    // Combinational output, forced low for as long as reset is asserted.
    always_comb begin
        SIG_OUT = RESET & stretch;
    end
`endif

endmodule

// File: tb/tb_signal_expansioner.sv
// Self-checking bench for signal_expansioner.
// Reference model: remembers the cycle of the last high SIG_IN and the
// EXTEND_LEN seen then; the output is high while SIG_IN is high or while
// fewer than EXTEND_LEN+1 cycles have elapsed since that last high cycle.
// Honours SIGNAL_EXPANSIONER_OUTPUT_REG_EN by delaying the expectation by one cycle.
module tb_signal_expansioner;

    localparam int W = 5;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [W-1:0] EXTEND_LEN = '0;
    logic         SIG_IN = 1'b0;
    logic         SIG_OUT;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    int   cyc     = 0;
    bit   hv      = 1'b0;
    int   last_hi = 0;
    int   hlen    = 0;
    logic exp_q   = 1'b0;

    // pulse-shape tallies over a scenario
    int   high_count = 0;
    int   rise_count = 0;
    logic prev_out   = 1'b0;

    signal_expansioner #(.MAX_EXTEND_LEN_WIDTH(W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .EXTEND_LEN (EXTEND_LEN),
        .SIG_IN     (SIG_IN),
        .SIG_OUT    (SIG_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic model_comb();
        logic ext;
        ext = hv && ((cyc - last_hi) <= hlen);
        return RESET && (SIG_IN || ext);
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        high_count = 0;
        rise_count = 0;
    endtask

    // One clock cycle: drive at negedge, check mid-low-phase, update model at posedge.
    task automatic step(input logic r, input logic s, input logic [W-1:0] l, input string tag);
        logic exp;
        @(negedge CLK);
        RESET      = r;
        SIG_IN     = s;
        EXTEND_LEN = l;
        #1;
`ifdef SIGNAL_EXPANSIONER_OUTPUT_REG_EN
        exp = exp_q;
`else
        exp = model_comb();
`endif
        check_bit(tag, SIG_OUT, exp);
        if (SIG_OUT === 1'b1 && prev_out !== 1'b1) rise_count++;
        if (SIG_OUT === 1'b1) high_count++;
        prev_out = SIG_OUT;
        @(posedge CLK);
        exp_q = model_comb();
        if (!r) begin
            hv = 1'b0;
        end else if (s) begin
            hv      = 1'b1;
            last_hi = cyc;
            hlen    = int'(l);
        end
        cyc++;
    endtask

    initial begin
        // settle state through one unchecked reset edge
        RESET = 1'b0;
        SIG_IN = 1'b1;
        @(posedge CLK);

        // 1: reset held with SIG_IN high, then release with counter empty
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5'd7, "reset_hold");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd7, "reset_release");

        // 2: 1-cycle pulse, EXTEND_LEN=5 -> 6 high cycles
        clear_tally();
        step(1'b1, 1'b1, 5'd5, "len5_pulse");
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 5'd5, "len5_tail");
        check_int("len5_width", high_count, 6);
        check_int("len5_rises", rise_count, 1);

        // 3: EXTEND_LEN=0 -> identical 3-cycle pulse
        clear_tally();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5'd0, "len0_pulse");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, "len0_tail");
        check_int("len0_width", high_count, 3);
        check_int("len0_rises", rise_count, 1);

        // 4a: two 2-cycle pulses, 3-cycle gap, EXTEND_LEN=4 -> merged 11 cycles
        clear_tally();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 5'd4, "merge_p1");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd4, "merge_gap");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 5'd4, "merge_p2");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'd4, "merge_tail");
        check_int("merge_width", high_count, 11);
        check_int("merge_rises", rise_count, 1);

        // 4b: same with a 6-cycle gap -> two separate 6-cycle pulses
        clear_tally();
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 5'd4, "split_p1");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 5'd4, "split_gap");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 5'd4, "split_p2");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 5'd4, "split_tail");
        check_int("split_width", high_count, 12);
        check_int("split_rises", rise_count, 2);

        // 5: maximum extension, EXTEND_LEN changed mid-extension is ignored
        clear_tally();
        step(1'b1, 1'b1, 5'd31, "max_pulse");
        for (int i = 1; i < 40; i++)
            step(1'b1, 1'b0, (i >= 10) ? 5'd2 : 5'd31, "max_tail");
        check_int("max_width", high_count, 32);
        check_int("max_rises", rise_count, 1);

        // 6: reset on the third extension cycle kills the extension
        clear_tally();
        step(1'b1, 1'b1, 5'd8, "rst_pulse");
        step(1'b1, 1'b0, 5'd8, "rst_ext1");
        step(1'b1, 1'b0, 5'd8, "rst_ext2");
        step(1'b0, 1'b0, 5'd8, "rst_ext3");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 5'd8, "rst_after");
        check_int("rst_width", high_count, 3);
        check_int("rst_rises", rise_count, 1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic         r;
            logic         s;
            logic [W-1:0] l;
            r = ($urandom_range(0, 29) != 0);
            s = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 31)) : W'($urandom_range(0, 6));
            step(r, s, l, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
